mix_fadd_seq: RTL

Parametrised, sequential floating add/subtract/compare unit for the MIX FPU. It accepts two MIX floating-point words (sign, one-byte excess-q exponent, NBYTES-byte fraction) on a start pulse. A small FSM then aligns, adds, normalises one byte per cycle and rounds. It returns the packed result with a done pulse, overflow flag and compare code. It replaces the fixed 6-bit/4-byte add path in the FPU and adds FCMP, reset and busy/done handshaking.

---
 rtl/mix_fadd_seq.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mix_fadd_seq.sv
// Sequential MIX floating add/subtract/compare: byte-wise align, add, normalise
// one byte per cycle, round, then present the packed result with a done pulse.
module mix_fadd_seq #(
  parameter int BYTE   = 6,
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [BYTE*(NBYTES+1):0] in1,
  input  logic [BYTE*(NBYTES+1):0] in2,
  output logic [BYTE*(NBYTES+1):0] out,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [1:0]               cmp
);

  localparam int W  = 1 + BYTE*(NBYTES+1);
  localparam int FW = BYTE*NBYTES;
  localparam int AW = 2*FW;
  localparam int EW = BYTE+2;
  localparam logic [BYTE:0]   DMAX  = (BYTE+1)'(2*NBYTES);
  localparam logic [EW-1:0]   E_ONE = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [1:0]      OP_FSUB = 2'b01;
  localparam logic [1:0]      OP_FCMP = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ALIGN = 3'd2,
    S_SUM   = 3'd3,
    S_NORM  = 3'd4,
    S_ROUND = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t          state_r;
  logic [1:0]      op_r;
  logic            sa_r, sb_r, eff_sub_r;
  logic [BYTE-1:0] ea_r, eb_r;
  logic [FW-1:0]   fa_r, fb_r;
  logic [AW:0]     acc_r;
  logic [EW-1:0]   exp_r;

  logic [FW+BYTE:0] key_a_s, key_b_s;
  logic             swap_s;
  logic [BYTE:0]    dexp_s;
  int               sh_s;
  logic [AW-1:0]    bal_s;
  logic [AW:0]      a_ext_s, sum_s;
  logic             rup_s, rzero_s, rovf_s;
  logic [FW:0]      rsum_s;
  logic [FW-1:0]    rfrac_s;
  logic [EW-1:0]    rexp_s;
  logic [W-1:0]     rpack_s;
  logic [1:0]       rcmp_s;

  // Datapath: magnitude compare, byte alignment, add/sub, rounding and packing.
  always_comb begin
    key_a_s = {|fa_r, ea_r, fa_r};
    key_b_s = {|fb_r, eb_r, fb_r};
    // A zero fraction always ranks below any nonzero one, whatever its exponent.
    swap_s  = (key_b_s > key_a_s);

    dexp_s = {1'b0, ea_r} - {1'b0, eb_r};
    sh_s   = int'(dexp_s) * BYTE;
    if (dexp_s[BYTE] || (dexp_s >= DMAX)) begin
      bal_s = {AW{1'b0}};
    end else begin
      bal_s = {fb_r, {FW{1'b0}}} >> sh_s;
    end

    a_ext_s = {1'b0, fa_r, {FW{1'b0}}};
    if (eff_sub_r) begin
      sum_s = a_ext_s - acc_r;
    end else begin
      sum_s = a_ext_s + acc_r;
    end

    // An exact half with an odd fraction truncates; any other set guard rounds up.
    rup_s  = acc_r[FW-1] & ~((acc_r[FW-2:0] == {(FW-1){1'b0}}) & acc_r[FW]);
    rsum_s = {1'b0, acc_r[AW-1:FW]} + {{FW{1'b0}}, rup_s};
    if (rsum_s[FW]) begin
      rfrac_s = {{(BYTE-1){1'b0}}, rsum_s[FW:BYTE]};
      rexp_s  = exp_r + E_ONE;
    end else begin
      rfrac_s = rsum_s[FW-1:0];
      rexp_s  = exp_r;
    end

    rzero_s = (rfrac_s == {FW{1'b0}});
    if (rzero_s) begin
      rpack_s = {sa_r, {BYTE{1'b0}}, rfrac_s};
    end else begin
      rpack_s = {sa_r, rexp_s[BYTE-1:0], rfrac_s};
    end

    if ((op_r == OP_FCMP) || rzero_s) begin
      rovf_s = 1'b0;
    end else begin
      rovf_s = rexp_s[EW-1] | rexp_s[BYTE];
    end

    if (op_r != OP_FCMP) begin
      rcmp_s = 2'b00;
    end else if (rzero_s) begin
      rcmp_s = 2'b00;
    end else if (sa_r) begin
      rcmp_s = 2'b01;
    end else begin
      rcmp_s = 2'b10;
    end
  end

  // Control FSM with registered outputs and operand/accumulator state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      op_r      <= 2'b00;
      sa_r      <= 1'b0;
      sb_r      <= 1'b0;
      eff_sub_r <= 1'b0;
      ea_r      <= {BYTE{1'b0}};
      eb_r      <= {BYTE{1'b0}};
      fa_r      <= {FW{1'b0}};
      fb_r      <= {FW{1'b0}};
      acc_r     <= {(AW+1){1'b0}};
      exp_r     <= {EW{1'b0}};
      out       <= {W{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      cmp       <= 2'b00;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            op_r    <= op;
            sa_r    <= in1[W-1];
            ea_r    <= in1[W-2:FW];
            fa_r    <= in1[FW-1:0];
            sb_r    <= in2[W-1] ^ ((op == OP_FSUB) || (op == OP_FCMP));
            eb_r    <= in2[W-2:FW];
            fb_r    <= in2[FW-1:0];
            busy    <= 1'b1;
            state_r <= S_LOAD;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (swap_s) begin
            sa_r <= sb_r;
            ea_r <= eb_r;
            fa_r <= fb_r;
            sb_r <= sa_r;
            eb_r <= ea_r;
            fb_r <= fa_r;
          end
          eff_sub_r <= sa_r ^ sb_r;
          state_r   <= S_ALIGN;
        end
        S_ALIGN: begin
          acc_r   <= {1'b0, bal_s};
          state_r <= S_SUM;
        end
        S_SUM: begin
          acc_r   <= sum_s;
          exp_r   <= {{(EW-BYTE){1'b0}}, ea_r};
          state_r <= S_NORM;
        end
        S_NORM: begin
          if (acc_r[AW]) begin
            acc_r   <= acc_r >> BYTE;
            exp_r   <= exp_r + E_ONE;
            state_r <= S_ROUND;
          end else if (acc_r == {(AW+1){1'b0}}) begin
            state_r <= S_ROUND;
          end else if (acc_r[AW-1:AW-BYTE] == {BYTE{1'b0}}) begin
            acc_r   <= acc_r << BYTE;
            exp_r   <= exp_r - E_ONE;
            state_r <= S_NORM;
          end else begin
            state_r <= S_ROUND;
          end
        end
        S_ROUND: begin
          out      <= rpack_s;
          overflow <= rovf_s;
          cmp      <= rcmp_s;
          done     <= 1'b1;
          state_r  <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
